// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the seven-segment capture block.
//   cap_state_t       : capture FSM states
//   SEG_BLANK         : all-segments-off pattern (active-low)
//   GLYPH             : active-low glyphs for hex digits 0..F
//   onehot_low_index  : qualifies an active-low anode bus -> {valid, index}
package seven_seg_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HELD} cap_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH [0:15] = '{
      7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
   };

   // Anode buses up to MAX_DIGITS wide are supported; narrower buses are
   // padded with 1s (inactive) by the caller.
   localparam int MAX_DIGITS = 32;
   localparam int MAX_IDXW   = 5;

   typedef struct packed {
      logic                valid;
      logic [MAX_IDXW-1:0] idx;
   } qual_t;

   // Valid only when exactly one bit is low; otherwise idle/illegal.
   function automatic qual_t onehot_low_index(input logic [MAX_DIGITS-1:0] e);
      qual_t r;
      int    n;
      r = '0;
      n = 0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (!e[i]) begin
            n++;
            r.idx = i[MAX_IDXW-1:0];
         end
      end
      r.valid = (n == 1);
      if (!r.valid) r.idx = '0;
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_capture_decode.sv
// seg7_decode: combinational active-low segment pattern -> hex nibble.
//   seg    : segments a..g at bits 6..0, active-low
//   nibble : decoded value (0 when blank or illegal)
//   blank  : pattern is all-off
//   err    : pattern is neither blank nor a hex glyph
module seg7_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       err
);

   logic hit;

   always_comb begin
      nibble = 4'h0;
      hit    = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (seg == GLYPH[k]) begin
            nibble = k[3:0];
            hit    = 1'b1;
         end
      end
      blank = (seg == SEG_BLANK);
      err   = !hit && !blank;
   end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: reads back a multiplexed 8-digit seven-segment display.
//   clk, reset  : clock, async active-high reset
//   en          : capture enable (low forces IDLE, outputs hold)
//   E, CA2G, dp : active-low anode bus, segments, decimal point
//   digits      : decoded nibbles, digit i at [4*i+3:4*i]
//   dp_out      : decimal point lit per digit
//   blank, err  : digit was all-off / not a legal glyph
//   frame_valid : one-cycle pulse when every digit has committed
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int NUM_DIGITS    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [NUM_DIGITS-1:0]   E,
   input  logic [6:0]              CA2G,
   input  logic                    dp,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic [NUM_DIGITS-1:0]   err,
   output logic                    frame_valid
);

   localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   // With a one-sample settle, the first qualified sample commits directly.
   localparam bit              DIRECT      = (SETTLE_CYCLES == 1);

   // sample stage
   logic [NUM_DIGITS-1:0] e_s;
   logic [6:0]            seg_s;
   logic                  dp_s;

   cap_state_t            state, state_n;
   logic [CW-1:0]         count, count_n;
   logic [MAX_IDXW-1:0]   cap_idx, cap_idx_n;
   logic [6:0]            cap_seg, cap_seg_n;
   logic                  cap_dp,  cap_dp_n;
   logic                  commit, start, same;

   logic [MAX_DIGITS-1:0] e_pad;
   qual_t                 q;
   logic [NUM_DIGITS-1:0] hit, seen, seen_set;
   logic [3:0]            nib;
   logic                  dec_blank, dec_err;

   always_comb begin
      e_pad                 = '1;
      e_pad[NUM_DIGITS-1:0] = e_s;
   end

   assign q    = onehot_low_index(e_pad);
   assign same = q.valid && (q.idx == cap_idx) && (seg_s == cap_seg) && (dp_s == cap_dp);

   // Commits always use the current sample: it either equals the capture or
   // is a fresh capture committing directly.
   seg7_decode u_dec (.seg(seg_s), .nibble(nib), .blank(dec_blank), .err(dec_err));

   always_comb begin
      state_n   = state;
      count_n   = count;
      cap_idx_n = cap_idx;
      cap_seg_n = cap_seg;
      cap_dp_n  = cap_dp;
      commit    = 1'b0;
      start     = 1'b0;
      if (!en) begin
         state_n = ST_IDLE;
         count_n = '0;
      end else begin
         case (state)
            ST_IDLE: start = q.valid;
            ST_SETTLE: begin
               if (same) begin
                  if (count == SETTLE_LAST) begin
                     commit  = 1'b1;
                     state_n = ST_HELD;
                  end else begin
                     count_n = count + CW'(1);
                  end
               end else if (q.valid) begin
                  start = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  count_n = '0;
               end
            end
            ST_HELD: begin
               if (!same) begin
                  if (q.valid) begin
                     start = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                     count_n = '0;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
               count_n = '0;
            end
         endcase
         if (start) begin
            cap_idx_n = q.idx;
            cap_seg_n = seg_s;
            cap_dp_n  = dp_s;
            count_n   = CW'(1);
            commit    = DIRECT;
            state_n   = DIRECT ? ST_HELD : ST_SETTLE;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++)
         hit[i] = commit && (q.idx == i[MAX_IDXW-1:0]);
   end

   assign seen_set = seen | hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_s         <= '1;
         seg_s       <= SEG_BLANK;
         dp_s        <= 1'b1;
         state       <= ST_IDLE;
         count       <= '0;
         cap_idx     <= '0;
         cap_seg     <= SEG_BLANK;
         cap_dp      <= 1'b1;
         digits      <= '0;
         dp_out      <= '0;
         blank       <= '0;
         err         <= '0;
         seen        <= '0;
         frame_valid <= 1'b0;
      end else begin
         e_s         <= E;
         seg_s       <= CA2G;
         dp_s        <= dp;
         state       <= state_n;
         count       <= count_n;
         cap_idx     <= cap_idx_n;
         cap_seg     <= cap_seg_n;
         cap_dp      <= cap_dp_n;
         frame_valid <= 1'b0;
         if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (hit[i]) begin
                  digits[4*i +: 4] <= nib;
                  dp_out[i]        <= ~dp_s;
                  blank[i]         <= dec_blank;
                  err[i]           <= dec_err;
               end
            end
            // The completing digit's seen bit is dropped with the rest.
            if (&seen_set) begin
               seen        <= '0;
               frame_valid <= 1'b1;
            end else begin
               seen <= seen_set;
            end
         end
      end
   end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the board's 8-digit multiplexed seven-segment driver.
- Samples the active-low anode bus, segment bus and decimal point, waits for each digit's pattern to settle, then decodes it back to a hex nibble.
- Rebuilds the full 8-digit frame and flags each complete scan.
- Used in loopback self-check and in benches to read back what the display driver is showing.

Parameters:
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is committed (min 1).
- NUM_DIGITS, 8: number of anodes/digits scanned.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  capture enable
- E  input  NUM_DIGITS  anode enables, active-low, one low at a time
- CA2G  input  7  segments, active-low; bit6=a, bit5=b … bit0=g
- dp  input  1  decimal point, active-low
- digits  output  4*NUM_DIGITS  decoded nibbles; digit i at [4*i+3:4*i]
- dp_out  output  NUM_DIGITS  dp_out[i]=1 when digit i's dp was lit
- blank  output  NUM_DIGITS  digit i was all-off (7'h7F)
- err  output  NUM_DIGITS  digit i's pattern was not a legal hex glyph
- frame_valid  output  1  one-cycle pulse when all digits are committed since the last pulse

Behaviour:
- Reset (async, active-high): all outputs 0, seen-mask 0, FSM in IDLE, settle counter 0, input sample registers loaded to idle values (E=all 1, CA2G=7'h7F, dp=1).
- Inputs are registered once (sample stage). All decisions use the sampled values.
- Anode qualification:
  - exactly one sampled E bit low → active index i;
  - no bit low → idle;
  - more than one low → illegal; treated as idle for that cycle.
- FSM states: IDLE, SETTLE, HELD.
  - IDLE: on a qualified index → SETTLE, capture (i, seg, dp), count=1.
  - SETTLE:
    - sample equals capture → count+1;
    - sample differs but is qualified → recapture, count=1;
    - idle/illegal → IDLE.
    - When count reaches SETTLE_CYCLES → commit and go to HELD.
  - HELD: remain while the sample equals the capture (no recommit within one dwell). On change → SETTLE with recapture if qualified, else IDLE.
- Latency: a pattern stable on the pins from cycle 0 is visible on the outputs after the edge ending cycle SETTLE_CYCLES (SETTLE_CYCLES+1 edges from first appearance).
- Commit of digit i, all in one cycle:
  - seg 7'h7F → nibble 0, blank[i]=1, err[i]=0;
  - legal glyph → nibble per table, blank[i]=0, err[i]=0;
  - any other pattern → nibble 0, blank[i]=0, err[i]=1;
  - dp_out[i] = ~dp;
  - seen[i] set.
- Glyph table (active-low): 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38.
- Frame completion: when a commit makes seen all-ones, frame_valid pulses that same edge and seen clears to 0. The completing digit's seen bit is not retained.
- Recommitting an already-seen digit overwrites its value; seen is unchanged.
- en low: FSM forced to IDLE, count 0, no commits. digits, dp_out, blank, err and seen hold their values. Capture resumes from IDLE when en returns high.
- Reset asserted mid-dwell or mid-frame discards everything; no frame_valid is produced.

Decomposition:
- Package seven_seg_pkg:
  - FSM state enum;
  - SEG_BLANK = 7'h7F;
  - 16-entry glyph constant array;
  - function onehot_low_index(E) returning {valid, index}.
- Sub-module seg7_decode: combinational 7-bit pattern → {nibble, blank, err}. Instantiated once.

Test Plan:
1. Reset held 100 ns, then released with E=8'hFF → all outputs 0, frame_valid never pulses.
2. E=8'hFE, CA2G=7'h12, dp=0 held 6 cycles → digits[3:0]=4'h2, dp_out[0]=1 exactly 5 edges after the pattern is applied, committed once.
3. Scan 8 digits showing 0..7 (glyphs 01,4F,12,06,4C,24,20,0F), 10 cycles each → digits=32'h76543210, a single frame_valid pulse on digit 7's commit.
4. Digit 3 held only 3 cycles (< SETTLE_CYCLES), then switched → no commit, seen[3]=0, frame_valid absent.
5. Digit 5 with CA2G=7'h7F, then digit 6 with CA2G=7'h55 → blank[5]=1; err[6]=1, digits[27:24]=0.
6. E=8'hFC (two low) for 8 cycles → nothing committed. Then en=0 during a valid dwell → outputs frozen. Then reset mid-frame → all outputs 0.
